// File: rtl/wam_game_core.sv
// Whack-a-mole game engine: LFSR-picked mole spawns, per-hole lifetimes,
// BCD hit score and a round timer paced by a divided game tick.
module wam_game_core #(
  parameter int          TICK_DIV      = 500000,
  parameter int          TICKS_PER_SEC = 100,
  parameter int          GAME_SECS     = 30,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [3:0]  hrdn,
  input  logic [7:0]  tap,
  output logic [7:0]  holes,
  output logic [11:0] score,
  output logic [4:0]  time_display,
  output logic        pause
);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  function automatic logic [3:0] clamp_lvl(input logic [3:0] h);
    if (h == 4'd0) return 4'd1;
    if (h > 4'd9)  return 4'd9;
    return h;
  endfunction

  function automatic logic [7:0] spawn_of(input logic [3:0] l);
    return 8'd120 - 8'd10 * {4'd0, l};
  endfunction

  function automatic logic [7:0] life_of(input logic [3:0] l);
    return 8'd200 - 8'd15 * {4'd0, l};
  endfunction

  // Digit-wise BCD add of a small count (0..8); a hundreds overflow pins at 999.
  function automatic logic [11:0] bcd_add(input logic [11:0] s, input logic [3:0] n);
    logic [4:0] d0, d1, d2;
    d0 = {1'b0, s[3:0]} + {1'b0, n};
    d1 = {1'b0, s[7:4]};
    d2 = {1'b0, s[11:8]};
    if (d0 > 5'd9) begin d0 = d0 - 5'd10; d1 = d1 + 5'd1; end
    if (d1 > 5'd9) begin d1 = d1 - 5'd10; d2 = d2 + 5'd1; end
    if (d2 > 5'd9) return 12'h999;
    return {d2[3:0], d1[3:0], d0[3:0]};
  endfunction

  state_t         r_state, w_state_nxt;
  logic [15:0]    r_lfsr;
  logic           r_start_q;
  logic [7:0]     r_tap_q;
  logic [TW-1:0]  r_tick_cnt;
  logic [SW-1:0]  r_sec_cnt;
  logic [3:0]     r_lvl;
  logic [7:0]     r_spawn_cnt;
  logic [7:0]     r_holes;
  logic [11:0]    r_score;
  logic [4:0]     r_time;

  logic       w_run, w_start_rise, w_enter, w_tick, w_sec_wrap, w_final, w_spawn_fire;
  logic [2:0] w_idx;
  logic [7:0] w_tap_rise, w_hit, w_expire, w_spawn_bit, w_holes_nxt;

  assign w_run        = (r_state == RUN);
  assign w_start_rise = start & ~r_start_q;
  assign w_enter      = ~w_run & w_start_rise;
  assign w_tick       = w_run && (r_tick_cnt == TW'(TICK_DIV - 1));
  assign w_sec_wrap   = w_tick && (r_sec_cnt == SW'(TICKS_PER_SEC - 1));
  assign w_final      = w_sec_wrap && (r_time == 5'd1);
  assign w_tap_rise   = tap & ~r_tap_q;
  assign w_hit        = w_run ? (w_tap_rise & r_holes) : 8'd0;
  assign w_idx        = r_lfsr[2:0];
  assign w_spawn_fire = w_tick && (r_spawn_cnt == 8'd1);
  // An occupied target (even one being hit this edge) makes the spawn a skip.
  assign w_spawn_bit  = (w_spawn_fire && !r_holes[w_idx]) ? (8'd1 << w_idx) : 8'd0;
  assign w_holes_nxt  = w_final ? 8'd0 : ((r_holes & ~w_hit & ~w_expire) | w_spawn_bit);

  for (genvar i = 0; i < 8; i++) begin : g_hole
    logic [7:0] r_life;
    assign w_expire[i] = w_tick & r_holes[i] & (r_life == 8'd1);
    always_ff @(posedge clk or posedge clr) begin
      if (clr)                                        r_life <= '0;
      else if (w_spawn_bit[i])                        r_life <= life_of(r_lvl);
      else if (w_tick && r_holes[i] && r_life != 8'd1) r_life <= r_life - 8'd1;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, OVER: if (w_start_rise) w_state_nxt = RUN;
      RUN:        if (w_final)      w_state_nxt = OVER;
      default:    w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_lfsr      <= LFSR_SEED;
      r_start_q   <= 1'b0;
      r_tap_q     <= 8'd0;
      r_tick_cnt  <= '0;
      r_sec_cnt   <= '0;
      r_lvl       <= 4'd1;
      r_spawn_cnt <= 8'd0;
      r_holes     <= 8'd0;
      r_score     <= 12'h000;
      r_time      <= 5'(GAME_SECS);
    end else begin
      r_lfsr    <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
      r_start_q <= start;
      r_tap_q   <= tap;
      if (w_enter) begin
        r_tick_cnt  <= '0;
        r_sec_cnt   <= '0;
        r_lvl       <= clamp_lvl(hrdn);
        r_spawn_cnt <= spawn_of(clamp_lvl(hrdn));
        r_holes     <= 8'd0;
        r_score     <= 12'h000;
        r_time      <= 5'(GAME_SECS);
      end else if (w_run) begin
        r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
        if (w_tick) begin
          r_sec_cnt   <= w_sec_wrap ? '0 : r_sec_cnt + SW'(1);
          r_spawn_cnt <= w_spawn_fire ? spawn_of(r_lvl) : r_spawn_cnt - 8'd1;
          if (w_sec_wrap && r_time != 5'd0) r_time <= r_time - 5'd1;
        end
        r_holes <= w_holes_nxt;
        r_score <= bcd_add(r_score, 4'($countones(w_hit)));
      end
    end
  end

  assign holes        = r_holes;
  assign score        = r_score;
  assign time_display = r_time;
  assign pause        = ~w_run;
endmodule
